// File: rtl/piece_bag_queue.sv
// piece_bag_queue: LFSR-driven piece generator (shuffled bags or uniform draws)
// feeding a small queue with a registered head and look-ahead preview.
module piece_bag_queue #(
    parameter int NUM_TYPES = 7,
    parameter int PIECE_W = 3,
    parameter int PREVIEW = 3,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seed_load,
    input  logic [LFSR_W-1:0]          seed_val,
    input  logic                       mode_random,
    input  logic                       pop,
    output logic                       piece_valid,
    output logic [PIECE_W-1:0]         piece,
    output logic [PREVIEW*PIECE_W-1:0] preview,
    output logic [PREVIEW-1:0]         preview_vld
);
    localparam int DEPTH = PREVIEW + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_TYPES);
    localparam int NW = $clog2(NUM_TYPES + 1);
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    typedef enum logic [1:0] {INIT, SHUFFLE, DRAIN} state_t;

    state_t state, state_next;
    logic [LFSR_W-1:0] lfsr;
    logic [PIECE_W-1:0] bag [NUM_TYPES];
    logic [PIECE_W-1:0] mem [DEPTH];
    logic [PIECE_W-1:0] mem_next [DEPTH];
    logic [PTR_W-1:0] head, head_next;
    logic [CNT_W-1:0] count, count_next;
    logic [IDX_W-1:0] i, k, j;
    logic mode, pop_ok, push;
    logic [PIECE_W-1:0] push_val, piece_next;
    logic [PREVIEW*PIECE_W-1:0] preview_next;
    logic [PREVIEW-1:0] vld_next;

    // (r * n) >> 8 maps an 8-bit random value onto 0..n-1
    function automatic logic [IDX_W-1:0] draw(input logic [7:0] r, input logic [NW-1:0] n);
        logic [NW+7:0] p;
        p = {{NW{1'b0}}, r} * {8'd0, n};
        return IDX_W'(p >> 8);
    endfunction

    function automatic logic [PTR_W-1:0] wrap(input int v);
        return PTR_W'(v >= DEPTH ? v - DEPTH : v);
    endfunction

    always_comb begin
        j = draw(lfsr[7:0], NW'(i) + NW'(1));
        pop_ok = pop && count != '0;
        push = state == DRAIN && (int'(count) < DEPTH || pop_ok);
        push_val = mode ? PIECE_W'(draw(lfsr[7:0], NW'(NUM_TYPES))) : bag[k];
        state_next = state == INIT ? (mode_random ? DRAIN : SHUFFLE) :
                     state == SHUFFLE ? (i == IDX_W'(1) ? DRAIN : SHUFFLE) :
                     (push && k == IDX_W'(NUM_TYPES - 1)) ? INIT : DRAIN;
        mem_next = mem;
        if (push)
            mem_next[wrap(int'(head) + int'(count))] = push_val;
        head_next = pop_ok ? wrap(int'(head) + 1) : head;
        count_next = count + CNT_W'(push) - CNT_W'(pop_ok);
        piece_next = count_next != '0 ? mem_next[head_next] : '0;
        for (int s = 0; s < PREVIEW; s++) begin
            vld_next[s] = int'(count_next) > s + 1;
            preview_next[s*PIECE_W +: PIECE_W] = vld_next[s] ? mem_next[wrap(int'(head_next) + s + 1)] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            lfsr <= SEED;
            head <= '0;
            count <= '0;
            mode <= 1'b0;
            i <= '0;
            k <= '0;
            piece_valid <= 1'b0;
            piece <= '0;
            preview <= '0;
            preview_vld <= '0;
            for (int n = 0; n < NUM_TYPES; n++) bag[n] <= '0;
            for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
        end else if (seed_load) begin
            state <= INIT;
            lfsr <= seed_val == '0 ? SEED : seed_val;
            head <= '0;
            count <= '0;
            k <= '0;
            piece_valid <= 1'b0;
            piece <= '0;
            preview <= '0;
            preview_vld <= '0;
        end else begin
            state <= state_next;
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
            mem <= mem_next;
            head <= head_next;
            count <= count_next;
            piece_valid <= count_next != '0;
            piece <= piece_next;
            preview <= preview_next;
            preview_vld <= vld_next;
            if (state == INIT) begin
                mode <= mode_random;
                i <= IDX_W'(NUM_TYPES - 1);
                k <= '0;
                for (int n = 0; n < NUM_TYPES; n++) bag[n] <= PIECE_W'(n);
            end
            if (state == SHUFFLE) begin
                bag[i] <= bag[j];
                bag[j] <= bag[i];
                i <= i - 1'b1;
            end
            if (push)
                k <= k == IDX_W'(NUM_TYPES - 1) ? '0 : k + 1'b1;
        end
    end
endmodule

// File: tb/tb_piece_bag_queue.sv
// tb_piece_bag_queue: directed scenarios for the piece generator, checked against
// a first-bag reference shuffle, permutation properties and stream repeatability.
module tb_piece_bag_queue;
    logic clk = 1'b0, reset = 1'b1, seed_load = 1'b0, mode_random = 1'b0, pop = 1'b0;
    logic [15:0] seed_val = '0;
    logic piece_valid;
    logic [2:0] piece;
    logic [8:0] preview;
    logic [2:0] preview_vld;
    int checks = 0, errors = 0;
    int got[$];
    int ref_s[$];
    int sav[$];
    int mb[7];

    always #5 clk = ~clk;

    piece_bag_queue dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_val(seed_val),
        .mode_random(mode_random), .pop(pop), .piece_valid(piece_valid),
        .piece(piece), .preview(preview), .preview_vld(preview_vld)
    );

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int drw(input logic [15:0] l, input int n);
        return (int'(l[7:0]) * n) >> 8;
    endfunction

    // expected first bag: INIT consumes one LFSR step, then Fisher-Yates for i=6..1
    task automatic model_bag(input logic [15:0] seed);
        logic [15:0] l;
        int t, jj;
        l = step(seed);
        for (int n = 0; n < 7; n++) mb[n] = n;
        for (int ii = 6; ii >= 1; ii--) begin
            jj = drw(l, ii + 1);
            t = mb[ii]; mb[ii] = mb[jj]; mb[jj] = t;
            l = step(l);
        end
    endtask

    function automatic bit is_perm(input int start);
        int mask;
        mask = 0;
        for (int t = 0; t < 7; t++) begin
            if (got[start+t] < 0 || got[start+t] > 6) return 1'b0;
            mask |= 1 << got[start+t];
        end
        return mask == 127;
    endfunction

    task automatic do_reset();
        pop = 1'b0;
        seed_load = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] v);
        @(posedge clk);
        #1 seed_val = v; seed_load = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
        checks++;
        if (piece_valid !== 1'b0 || preview_vld !== 3'b000) begin
            errors++;
            $display("FAIL seed_clear valid=%b pvld=%b expected 0/000", piece_valid, preview_vld);
        end
    endtask

    task automatic collect(input int n);
        int budget;
        got.delete();
        budget = n * 4 + 200;
        while (got.size() < n && budget > 0) begin
            @(negedge clk);
            if (piece_valid) got.push_back(int'(piece));
            pop = piece_valid;
            budget--;
        end
        @(posedge clk);
        #1 pop = 1'b0;
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL collect got %0d ids, expected %0d", got.size(), n);
            while (got.size() < n) got.push_back(-1);
        end
    endtask

    task automatic check_prefix(input string name, input int n);
        bit bad;
        bad = 1'b0;
        for (int t = 0; t < n; t++) if (got[t] != ref_s[t]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s first %0d ids got %0d,%0d,%0d expected %0d,%0d,%0d",
                     name, n, got[0], got[1], got[2], ref_s[0], ref_s[1], ref_s[2]);
        end
    endtask

    task automatic check_bag(input string name);
        bit bad;
        bad = 1'b0;
        for (int t = 0; t < 7; t++) if (got[t] != mb[t]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s got %0d%0d%0d%0d%0d%0d%0d expected %0d%0d%0d%0d%0d%0d%0d", name,
                     got[0], got[1], got[2], got[3], got[4], got[5], got[6],
                     mb[0], mb[1], mb[2], mb[3], mb[4], mb[5], mb[6]);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (piece_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", piece_valid); end
        if (piece !== 3'd0) begin errors++; $display("FAIL reset_piece got %0d expected 0", piece); end
        if (preview !== 9'd0) begin errors++; $display("FAIL reset_preview got %h expected 0", preview); end
        if (preview_vld !== 3'b000) begin errors++; $display("FAIL reset_pvld got %b expected 000", preview_vld); end
    endtask

    task automatic test_fill();
        logic [8:0] exp_pv;
        do_reset();
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (piece_valid !== 1'b0) begin errors++; $display("FAIL latency_early valid=%b expected 0", piece_valid); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (piece_valid !== 1'b1) begin errors++; $display("FAIL latency valid=%b expected 1", piece_valid); end
        if (piece !== 3'(mb[0])) begin errors++; $display("FAIL first_piece got %0d expected %0d", piece, mb[0]); end
        repeat (10) @(negedge clk);
        exp_pv = {3'(mb[3]), 3'(mb[2]), 3'(mb[1])};
        checks += 3;
        if (preview_vld !== 3'b111) begin errors++; $display("FAIL full_pvld got %b expected 111", preview_vld); end
        if (piece !== 3'(mb[0])) begin errors++; $display("FAIL full_head got %0d expected %0d", piece, mb[0]); end
        if (preview !== exp_pv) begin errors++; $display("FAIL full_preview got %h expected %h", preview, exp_pv); end
    endtask

    task automatic test_back_to_back();
        pop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (preview_vld !== 3'b111 || piece !== 3'(mb[c+1]) || preview[8:6] !== 3'(mb[c+4])) begin
                errors++;
                $display("FAIL b2b_%0d pvld=%b head=%0d tail=%0d expected 111 %0d %0d",
                         c, preview_vld, piece, preview[8:6], mb[c+1], mb[c+4]);
            end
        end
        pop = 1'b0;
    endtask

    task automatic test_empty_pop();
        do_reset();
        pop = 1'b1;
        repeat (5) @(posedge clk);
        #1 pop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (piece_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_early valid=%b expected 0", piece_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (piece_valid !== 1'b1) begin errors++; $display("FAIL empty_pop_latency valid=%b expected 1", piece_valid); end
        collect(7);
        check_bag("empty_pop_bag");
    endtask

    task automatic test_perm();
        int nbad;
        do_reset();
        collect(700);
        ref_s = got;
        check_bag("perm_first_bag");
        nbad = 0;
        for (int g = 0; g < 100; g++) if (!is_perm(g * 7)) nbad++;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL perm_groups bad=%0d expected 0", nbad); end
    endtask

    task automatic test_seed();
        load_seed(16'h1234);
        collect(50);
        sav = got;
        model_bag(16'h1234);
        check_bag("seed_1234_bag");
        load_seed(16'h1234);
        collect(50);
        ref_s = sav;
        check_prefix("seed_repeat", 50);
        model_bag(16'hACE1);
        load_seed(16'h0000);
        collect(50);
        check_bag("seed_zero_bag");
    endtask

    task automatic test_mode();
        int hist[7];
        do_reset();
        repeat (9) @(posedge clk);
        #1 mode_random = 1'b1;
        collect(7);
        check_bag("mode_switch_bag");
        collect(7000);
        for (int v = 0; v < 7; v++) hist[v] = 0;
        for (int t = 0; t < 7000; t++) if (got[t] >= 0 && got[t] < 7) hist[got[t]]++;
        for (int v = 0; v < 7; v++) begin
            checks++;
            if (hist[v] < 850 || hist[v] > 1150) begin
                errors++;
                $display("FAIL random_hist id %0d count %0d expected 850..1150", v, hist[v]);
            end
        end
        do_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (piece_valid !== 1'b0) begin errors++; $display("FAIL rnd_latency_early valid=%b expected 0", piece_valid); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (piece_valid !== 1'b1) begin errors++; $display("FAIL rnd_latency valid=%b expected 1", piece_valid); end
        if (piece !== 3'(drw(step(16'hACE1), 7))) begin
            errors++;
            $display("FAIL rnd_first got %0d expected %0d", piece, drw(step(16'hACE1), 7));
        end
        mode_random = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        collect(14);
        ref_s = got;
        do_reset();
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (piece_valid !== 1'b0 || preview_vld !== 3'b000) begin
            errors++;
            $display("FAIL rst_shuffle valid=%b pvld=%b expected 0/000", piece_valid, preview_vld);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        collect(14);
        check_prefix("rst_shuffle_stream", 14);
        repeat (12) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (piece_valid !== 1'b0 || piece !== 3'd0 || preview !== 9'd0 || preview_vld !== 3'b000) begin
            errors++;
            $display("FAIL rst_drain valid=%b piece=%0d prev=%h pvld=%b expected all 0",
                     piece_valid, piece, preview, preview_vld);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        collect(14);
        check_prefix("rst_drain_stream", 14);
    endtask

    initial begin
        model_bag(16'hACE1);
        test_reset();
        test_fill();
        test_back_to_back();
        test_empty_pop();
        test_perm();
        test_seed();
        test_mode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
